// File: rtl/jtag_ir_reg.sv
// JTAG instruction register: capture/shift stage plus legalising update stage.
// Sits between the TAP controller strobes and the DR multiplexer select logic.
module jtag_ir_reg #(
    parameter int unsigned        IR_W         = 4,
    parameter logic [IR_W-1:0]    RESET_INSTR  = IR_W'(1),
    parameter logic [IR_W-1:0]    BYPASS_INSTR = {IR_W{1'b1}},
    parameter logic [2**IR_W-1:0] LEGAL_MAP    = (2**IR_W)'(16'h800F)
) (
    input  logic            ICLK,
    input  logic            reset,
    input  logic            clk_ir,
    input  logic            shift_ir,
    input  logic            update_ir,
    input  logic            s_data_in,
    output logic            s_data_out,
    input  logic [IR_W-3:0] p_status_in,
    output logic [IR_W-1:0] p_data_out,
    output logic            bypass_sel,
    output logic            ir_illegal,
    output logic            ir_len_err
);

    localparam int unsigned CNT_W = $clog2(IR_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IR_W);

    logic [IR_W-1:0]  sr;
    logic [IR_W-1:0]  upd;
    logic [CNT_W-1:0] cnt;
    logic [IR_W-1:0]  capture_val;
    logic             opcode_legal;
    logic             short_scan;

    // Low two bits are fixed at 2'b01 as IEEE 1149.1 requires on Capture-IR.
    generate
        if (IR_W > 2) begin : g_status
            assign capture_val = {p_status_in, 2'b01};
        end else begin : g_no_status
            assign capture_val = IR_W'(2'b01);
        end
    endgenerate

    assign opcode_legal = LEGAL_MAP[sr];
    assign short_scan   = (cnt != '0) && (cnt < CNT_MAX);

    always_ff @(posedge ICLK) begin
        if (!reset) begin
            sr         <= IR_W'(2'b01);
            upd        <= RESET_INSTR;
            cnt        <= '0;
            ir_illegal <= 1'b0;
            ir_len_err <= 1'b0;
        end else begin
            if (clk_ir) begin
                if (shift_ir) begin
                    sr <= {s_data_in, sr[IR_W-1:1]};
                    if (cnt < CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end else begin
                    sr  <= capture_val;
                    cnt <= '0;
                end
            end
            // Update samples the pre-edge shift state, so a coincident shift is harmless.
            if (update_ir) begin
                upd        <= opcode_legal ? sr : BYPASS_INSTR;
                ir_illegal <= ~opcode_legal;
                ir_len_err <= short_scan;
            end
        end
    end

    assign s_data_out = sr[0];
    assign p_data_out = upd;
    assign bypass_sel = (upd == BYPASS_INSTR);

endmodule
